// File: rtl/l2_bank_fill_check_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_bank_fill_check_if : 32-bit UNICAD-style SRAM bank port bundle     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface l2_bank_fill_check_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic                    csn;
  logic                    wen;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ADDR_WIDTH-1:0]   add;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    gnt;

  modport master (output csn, wen, be, add, wdata, input rdata, gnt);
  modport slave  (input csn, wen, be, add, wdata, output rdata, gnt);
endinterface
`default_nettype wire

// File: rtl/l2_bank_fill_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | l2_bank_fill_check : fills / reads back / compares a window of one    |
// | L2 bank with a deterministic pattern.           Revision: 1.0         |
// +----------------------------------------------------------------------+
module l2_bank_fill_check #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  wire                    clk_i,
  input  wire                    rst_i,
  input  wire                    start_i,
  input  wire [1:0]              mode_i,
  input  wire [ADDR_WIDTH-1:0]   base_addr_i,
  input  wire [ADDR_WIDTH:0]     num_words_i,
  input  wire [DATA_WIDTH-1:0]   pattern_i,
  input  wire                    addr_xor_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic [CNT_WIDTH-1:0]   err_count_o,
  output logic [ADDR_WIDTH-1:0]  first_err_addr_o,
  l2_bank_fill_check_if.master   mem
);

  localparam int c_BE_WIDTH  = DATA_WIDTH / 8;
  localparam int c_EXT_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   c_REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_CHECK = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic [CNT_WIDTH-1:0]    r_err_count;
  logic [ADDR_WIDTH-1:0]   r_first_err_addr;
  logic                    r_csn;
  logic                    r_wen;
  logic [c_BE_WIDTH-1:0]   r_be;
  logic [ADDR_WIDTH-1:0]   r_add;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH:0]     r_num;
  logic [ADDR_WIDTH:0]     r_remaining;
  logic [DATA_WIDTH-1:0]   r_pattern;
  logic                    r_xor;
  logic                    r_fill_then_check;
  logic                    r_cmp_valid;
  logic [ADDR_WIDTH-1:0]   r_cmp_addr;
  logic [DATA_WIDTH-1:0]   r_cmp_exp;

  logic                    w_accept;
  logic                    w_last;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic                    w_mismatch;

  // Address is zero-extended (or truncated) to the data width before the XOR.
  function automatic logic [DATA_WIDTH-1:0] exp_data(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] p,
                                                     input logic x);
    logic [c_EXT_WIDTH-1:0] ext;
    ext = c_EXT_WIDTH'(a);
    return x ? (p ^ ext[DATA_WIDTH-1:0]) : p;
  endfunction

  assign w_accept    = ~r_csn & mem.gnt;
  assign w_last      = (r_remaining == c_REM_ONE);
  assign w_next_addr = r_add + c_ADDR_ONE;
  assign w_mismatch  = r_cmp_valid && (mem.rdata != r_cmp_exp);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state           <= S_IDLE;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_err             <= 1'b0;
      r_err_count       <= '0;
      r_first_err_addr  <= '0;
      r_csn             <= 1'b1;
      r_wen             <= 1'b1;
      r_be              <= '0;
      r_add             <= '0;
      r_wdata           <= '0;
      r_base            <= '0;
      r_num             <= '0;
      r_remaining       <= '0;
      r_pattern         <= '0;
      r_xor             <= 1'b0;
      r_fill_then_check <= 1'b0;
      r_cmp_valid       <= 1'b0;
      r_cmp_addr        <= '0;
      r_cmp_exp         <= '0;
    end else begin
      r_cmp_valid <= 1'b0;

      // The compare stage trails the read by one cycle in CHECK and DRAIN.
      if (w_mismatch) begin
        r_err <= 1'b1;
        if (r_err_count != c_CNT_MAX) r_err_count <= r_err_count + c_CNT_ONE;
        if (r_err_count == '0) r_first_err_addr <= r_cmp_addr;
      end

      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_base            <= base_addr_i;
            r_num             <= num_words_i;
            r_remaining       <= num_words_i;
            r_pattern         <= pattern_i;
            r_xor             <= addr_xor_i;
            r_fill_then_check <= (mode_i == 2'b10);
            r_err             <= 1'b0;
            r_err_count       <= '0;
            r_first_err_addr  <= '0;
            r_busy            <= 1'b1;
            if (num_words_i == '0) begin
              // An empty window still spends one busy cycle before done.
              r_state <= S_DRAIN;
            end else begin
              r_csn <= 1'b0;
              r_be  <= '1;
              r_add <= base_addr_i;
              if (mode_i == 2'b01) begin
                r_wen   <= 1'b1;
                r_state <= S_CHECK;
              end else begin
                r_wen   <= 1'b0;
                r_wdata <= exp_data(base_addr_i, pattern_i, addr_xor_i);
                r_state <= S_FILL;
              end
            end
          end
        end

        S_FILL: begin
          if (w_accept) begin
            if (w_last) begin
              if (r_fill_then_check) begin
                r_wen       <= 1'b1;
                r_add       <= r_base;
                r_remaining <= r_num;
                r_state     <= S_CHECK;
              end else begin
                r_csn   <= 1'b1;
                r_wen   <= 1'b1;
                r_be    <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end else begin
              r_add       <= w_next_addr;
              r_wdata     <= exp_data(w_next_addr, r_pattern, r_xor);
              r_remaining <= r_remaining - c_REM_ONE;
            end
          end
        end

        S_CHECK: begin
          if (w_accept) begin
            r_cmp_valid <= 1'b1;
            r_cmp_addr  <= r_add;
            r_cmp_exp   <= exp_data(r_add, r_pattern, r_xor);
            if (w_last) begin
              r_csn   <= 1'b1;
              r_be    <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_add       <= w_next_addr;
              r_remaining <= r_remaining - c_REM_ONE;
            end
          end
        end

        S_DRAIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign err_o            = r_err;
  assign err_count_o      = r_err_count;
  assign first_err_addr_o = r_first_err_addr;
  assign mem.csn          = r_csn;
  assign mem.wen          = r_wen;
  assign mem.be           = r_be;
  assign mem.add          = r_add;
  assign mem.wdata        = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_l2_bank_fill_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_l2_bank_fill_check : bench for l2_bank_fill_check with a bank model|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_l2_bank_fill_check;
  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int CW   = 16;
  localparam int MASK = (1 << AW) - 1;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    be;
  } acc_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic [DW-1:0] pattern = '0;
  logic          addr_xor = 1'b0;
  logic          busy, done, err;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_addr;

  l2_bank_fill_check_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  l2_bank_fill_check #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .mode_i           (mode),
    .base_addr_i      (base_addr),
    .num_words_i      (num_words),
    .pattern_i        (pattern),
    .addr_xor_i       (addr_xor),
    .busy_o           (busy),
    .done_o           (done),
    .err_o            (err),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr),
    .mem              (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural bank: one-cycle read latency, optional per-word corruption.
  logic [DW-1:0] bank [0:MASK];
  logic [DW-1:0] corrupt [int];
  int gnt_pct = 100;

  function automatic logic [DW-1:0] corr(input int a);
    return corrupt.exists(a) ? corrupt[a] : '0;
  endfunction

  function automatic logic [DW-1:0] dat(input int a, input logic [DW-1:0] p, input bit x);
    return x ? (p ^ DW'(a & MASK)) : p;
  endfunction

  always @(posedge clk) begin
    #1;
    bus.gnt = ($urandom_range(0, 99) < gnt_pct);
  end

  always @(posedge clk) begin
    if (!bus.csn && bus.gnt) begin
      if (!bus.wen) begin
        for (int b = 0; b < 4; b++)
          if (bus.be[b]) bank[bus.add][8*b +: 8] = bus.wdata[8*b +: 8];
      end else begin
        bus.rdata <= bank[bus.add] ^ corr(int'(bus.add));
      end
    end
  end

  // Bus monitor: records accepted accesses and checks hold-while-ungranted.
  acc_t          acc_q[$];
  int            csn_low = 0;
  bit            hold_pending = 1'b0;
  logic [63:0]   held_bus = '0;

  always @(negedge clk) begin
    if (hold_pending && !rst)
      check_eq("bus_hold", {bus.csn, bus.wen, bus.be, bus.add, bus.wdata}, held_bus);
    hold_pending = !rst && !bus.csn && !bus.gnt;
    held_bus     = {bus.csn, bus.wen, bus.be, bus.add, bus.wdata};
    if (!rst && !bus.csn) begin
      csn_low++;
      if (bus.gnt)
        acc_q.push_back('{wr: ~bus.wen, addr: bus.add,
                          data: (bus.wen ? '0 : bus.wdata), be: bus.be});
    end
  end

  task automatic run_op(input logic [1:0] md, input int b, input int n, input logic [DW-1:0] p,
                        input bit x, input int gp, input bit abuse, input bit prefill);
    acc_t exp_q[$];
    bit   do_fill, do_check;
    int   e_cnt, e_first, done_k, exp_lat, nmin;
    logic [DW-1:0] content;
    do_fill  = (md != 2'b01);
    do_check = (md == 2'b01) || (md == 2'b10);
    e_cnt    = 0;
    e_first  = 0;
    if (prefill)
      for (int i = 0; i < n; i++) bank[(b + i) & MASK] = dat(b + i, p, x);
    if (do_fill)
      for (int i = 0; i < n; i++)
        exp_q.push_back('{wr: 1'b1, addr: AW'((b + i) & MASK), data: dat(b + i, p, x), be: 4'hf});
    if (do_check)
      for (int i = 0; i < n; i++) begin
        exp_q.push_back('{wr: 1'b0, addr: AW'((b + i) & MASK), data: '0, be: 4'hf});
        content = (do_fill ? dat(b + i, p, x) : bank[(b + i) & MASK]) ^ corr((b + i) & MASK);
        if (content != dat(b + i, p, x)) begin
          if (e_cnt == 0) e_first = (b + i) & MASK;
          e_cnt++;
        end
      end
    exp_lat = (n == 0) ? 2 : ((do_fill ? n : 0) + (do_check ? n : 0) + (do_check ? 2 : 1));

    gnt_pct = gp;
    acc_q.delete();
    csn_low = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = md; base_addr = AW'(b); num_words = (AW+1)'(n);
    pattern = p; addr_xor = x;
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom); pattern = $urandom; addr_xor = ~x; mode = ~md;
    done_k = 0;
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      if (k == 1) check_eq("busy_after_start", busy, 1);
      if (abuse && k == 3) start = 1'b1;
      if (abuse && k == 5) start = 1'b0;
      if (done) begin
        done_k = k;
        break;
      end
    end
    start = 1'b0;
    check_eq("done_seen", (done_k != 0), 1);
    if (done_k != 0) begin
      check_eq("busy_at_done", busy, 0);
      if (gp == 100) begin
        check_eq("done_latency", done_k, exp_lat);
        check_eq("csn_low_cycles", csn_low, exp_q.size());
      end
      check_eq("err_flag", err, (e_cnt != 0));
      check_eq("err_count", err_count, e_cnt);
      check_eq("first_err_addr", first_err_addr, e_first);
      check_eq("num_accesses", acc_q.size(), exp_q.size());
      nmin = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
      for (int i = 0; i < nmin; i++) check_eq("access", acc_q[i], exp_q[i]);
      @(negedge clk);
      check_eq("done_one_cycle", done, 0);
      check_eq("idle_bus", {bus.csn, bus.wen, bus.be}, {1'b1, 1'b1, 4'h0});
      check_eq("err_count_stable", err_count, e_cnt);
    end
  endtask

  initial begin
    bus.gnt = 1'b1;
    for (int i = 0; i <= MASK; i++) bank[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_status", {busy, done, err, err_count, first_err_addr}, '0);
    check_eq("rst_bus_ctl", {bus.csn, bus.wen, bus.be}, {1'b1, 1'b1, 4'h0});
    check_eq("rst_bus_addr_data", {bus.add, bus.wdata}, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill window 0x10..0x13 with pattern ^ address.
    run_op(2'b00, 'h10, 4, 32'hA5A5_0000, 1'b1, 100, 1'b0, 1'b0);
    check_eq("fill_word0", acc_q.size() > 0 ? acc_q[0].data : '0, 32'hA5A5_0010);
    check_eq("fill_word3", acc_q.size() > 3 ? acc_q[3].data : '0, 32'hA5A5_0013);

    run_op(2'b10, 0, 8, 32'h1234_5678, 1'b0, 100, 1'b0, 1'b0);

    // Two corrupted words inside a 16-word check.
    corrupt.delete();
    corrupt[5] = 32'h0000_0100;
    corrupt[9] = 32'h8000_0000;
    run_op(2'b01, 0, 16, 32'hC0DE_0000, 1'b1, 100, 1'b0, 1'b1);
    check_eq("inj_count", err_count, 2);
    check_eq("inj_first", first_err_addr, 5);
    corrupt.delete();

    run_op(2'b10, 'h200, 20, 32'h5A5A_F00F, 1'b1, 50, 1'b0, 1'b0);
    run_op(2'b10, 'h300, 0, 32'hFFFF_FFFF, 1'b0, 100, 1'b0, 1'b0);
    run_op(2'b10, 'h3FFE, 4, 32'h0F0F_0000, 1'b1, 100, 1'b0, 1'b0);
    check_eq("wrap_addr2", acc_q.size() > 2 ? acc_q[2].addr : '1, 0);
    run_op(2'b00, 'h40, 20, 32'hDEAD_BEEF, 1'b0, 100, 1'b1, 1'b0);
    run_op(2'b11, 'h80, 3, 32'h0000_00FF, 1'b1, 100, 1'b0, 1'b0);

    // Reset while CHECK is accumulating errors.
    corrupt.delete();
    corrupt['h100] = 32'h1;
    corrupt['h101] = 32'h2;
    for (int i = 0; i < 16; i++) bank['h100 + i] = 32'h7777_0000;
    gnt_pct = 100;
    @(posedge clk); #1;
    start = 1'b1; mode = 2'b01; base_addr = 'h100; num_words = 16;
    pattern = 32'h7777_0000; addr_xor = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("pre_reset_errs", (err_count != 0), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_status", {busy, done, err, err_count}, '0);
    check_eq("midrst_csn", bus.csn, 1);
    corrupt.delete();

    for (int t = 0; t < 8; t++) begin
      logic [1:0] md;
      int b, n;
      md = 2'($urandom_range(0, 3));
      b  = $urandom_range(0, MASK);
      n  = $urandom_range(0, 24);
      corrupt.delete();
      if ($urandom_range(0, 1) == 1)
        corrupt[(b + $urandom_range(0, n)) & MASK] = 32'h1 << $urandom_range(0, 31);
      run_op(md, b, n, $urandom, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? 100 : 50, 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
